// File: rtl/instr_pkg.sv
// Shared types and constants for the instruction fetch/decode front end.
// Branch opcodes are resolved only when INSTR_FETCH_BRANCH_EN is defined.
package instr_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_W    = 8;
    localparam int SEL_W   = 2;
    localparam int RD_W    = 4;
    localparam int FIELD_W = 8;

    localparam logic [OP_W-1:0] OP_JMP   = 8'h12;
    localparam logic [OP_W-1:0] OP_JMPC  = 8'h13;
    localparam logic [OP_W-1:0] OP_JMPCN = 8'h14;
    localparam logic [OP_W-1:0] OP_HALT  = 8'hFF;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 24;
    localparam int SRC1_MSB = 23;
    localparam int SRC1_LSB = 22;
    localparam int SRC2_MSB = 21;
    localparam int SRC2_LSB = 20;
    localparam int RD_MSB   = 19;
    localparam int RD_LSB   = 16;
    localparam int FA_MSB   = 15;
    localparam int FA_LSB   = 8;
    localparam int FB_MSB   = 7;
    localparam int FB_LSB   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]    op_code;
        logic [SEL_W-1:0]   source1_choice;
        logic [SEL_W-1:0]   source2_choice;
        logic [RD_W-1:0]    rd;
        logic [FIELD_W-1:0] field_a;
        logic [FIELD_W-1:0] field_b;
    } dec_fields_t;

    function automatic logic is_branch(input logic [OP_W-1:0] op);
        return (op == OP_JMP) || (op == OP_JMPC) || (op == OP_JMPCN);
    endfunction

    function automatic logic branch_taken(input logic [OP_W-1:0] op, input logic cond);
        return (op == OP_JMP) || ((op == OP_JMPC) && cond) || ((op == OP_JMPCN) && !cond);
    endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Program-memory fetch port and decoded-field handshake to the execute stage.
// master = fetch/decode front end, slave = memory plus execute side.
interface instr_fetch_decode_if #(
    parameter int PC_WIDTH = 8,
    parameter int IWIDTH   = 8,
    parameter int WIDTH    = 8,
    parameter int SOURCES  = 4
);
    localparam int SEL_WIDTH = $clog2(SOURCES);

    logic                 imem_req;
    logic [PC_WIDTH-1:0]  imem_addr;
    logic                 imem_valid;
    logic [31:0]          imem_data;

    logic                 dec_valid;
    logic                 dec_ready;
    logic [IWIDTH-1:0]    op_code;
    logic [SEL_WIDTH-1:0] source1_choice;
    logic [SEL_WIDTH-1:0] source2_choice;
    logic [3:0]           rd;
    logic [WIDTH-1:0]     field_a;
    logic [WIDTH-1:0]     field_b;

    modport master (
        output imem_req, imem_addr,
        input  imem_valid, imem_data,
        output dec_valid, op_code, source1_choice, source2_choice, rd, field_a, field_b,
        input  dec_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_valid, imem_data,
        input  dec_valid, op_code, source1_choice, source2_choice, rd, field_a, field_b,
        output dec_ready
    );

endinterface

// File: rtl/instr_field_split.sv
// Combinational split of a 32-bit instruction word into the decoded bundle.
module instr_field_split
    import instr_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output dec_fields_t        fields
);

    assign fields.op_code        = instr[OP_MSB:OP_LSB];
    assign fields.source1_choice = instr[SRC1_MSB:SRC1_LSB];
    assign fields.source2_choice = instr[SRC2_MSB:SRC2_LSB];
    assign fields.rd             = instr[RD_MSB:RD_LSB];
    assign fields.field_a        = instr[FA_MSB:FA_LSB];
    assign fields.field_b        = instr[FB_MSB:FB_LSB];

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: PC sequencing, one-outstanding fetch, decode handoff.
// Define INSTR_FETCH_BRANCH_EN to resolve JMP/JMPC/JMPCN locally.
//
// state    | meaning
// IDLE     | quiescent, waiting for run
// FETCH    | one-cycle imem_req at pc
// WAIT     | waiting for imem_valid, then latch instruction
// ISSUE    | present fields to execute, or resolve jump/halt
// HALT     | HALT retired, held until rst
module instr_fetch_decode
    import instr_pkg::*;
#(
    parameter int PC_WIDTH = 8,
    parameter int IWIDTH   = 8,
    parameter int WIDTH    = 8,
    parameter int SOURCES  = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  cond_in,
    instr_fetch_decode_if.master  bus,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  halted
);

    localparam int SEL_WIDTH = $clog2(SOURCES);

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc_nxt;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [INSTR_W-1:0]  ir;
    logic                ir_load;
    logic                halted_nxt;
    state_t              exit_state;
    dec_fields_t         fields;

    instr_field_split u_split (
        .instr  (ir),
        .fields (fields)
    );

    assign pc_inc     = pc + PC_WIDTH'(1);
    assign exit_state = run ? ST_FETCH : ST_IDLE;

`ifdef INSTR_FETCH_BRANCH_EN
    logic [PC_WIDTH-1:0] jump_target;
    assign jump_target = PC_WIDTH'(fields.field_b);
`else
    logic unused_cond;
    assign unused_cond = cond_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            pc     <= '0;
            ir     <= '0;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            halted <= halted_nxt;
            if (ir_load) begin
                ir <= bus.imem_data;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        ir_load       = 1'b0;
        halted_nxt    = halted;
        bus.imem_req  = 1'b0;
        bus.dec_valid = 1'b0;

        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_valid) begin
                    ir_load   = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fields.op_code == OP_HALT) begin
                    halted_nxt = 1'b1;
                    state_nxt  = ST_HALT;
                end
`ifdef INSTR_FETCH_BRANCH_EN
                else if (is_branch(fields.op_code)) begin
                    pc_nxt    = branch_taken(fields.op_code, cond_in) ? jump_target : pc_inc;
                    state_nxt = exit_state;
                end
`endif
                else begin
                    // pc and fields stay frozen until execute takes the bundle
                    bus.dec_valid = 1'b1;
                    if (bus.dec_ready) begin
                        pc_nxt    = pc_inc;
                        state_nxt = exit_state;
                    end
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.imem_addr      = pc;
    assign bus.op_code        = IWIDTH'(fields.op_code);
    assign bus.source1_choice = SEL_WIDTH'(fields.source1_choice);
    assign bus.source2_choice = SEL_WIDTH'(fields.source2_choice);
    assign bus.rd             = fields.rd;
    assign bus.field_a        = WIDTH'(fields.field_a);
    assign bus.field_b        = WIDTH'(fields.field_b);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed self-checking bench for instr_fetch_decode with a zero-wait memory model.
module tb_instr_fetch_decode;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       cond_in;
    logic [7:0] pc;
    logic       halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [256];

    instr_fetch_decode_if #(.PC_WIDTH(8), .IWIDTH(8), .WIDTH(8), .SOURCES(4)) bus ();

    instr_fetch_decode #(.PC_WIDTH(8), .IWIDTH(8), .WIDTH(8), .SOURCES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .cond_in (cond_in),
        .bus     (bus),
        .pc      (pc),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    // zero-wait program memory, sharing rst with the front end
    always @(posedge clk) begin
        if (rst) begin
            bus.imem_valid <= 1'b0;
            bus.imem_data  <= '0;
        end else begin
            bus.imem_valid <= bus.imem_req;
            bus.imem_data  <= mem[bus.imem_addr];
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill_mem(input logic [31:0] word);
        for (int i = 0; i < 256; i++) mem[i] = word;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; cond_in = 1'b0; bus.dec_ready = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        fill_mem(32'h01000000);
        rst = 1'b1; run = 1'b1; cond_in = 1'b0; bus.dec_ready = 1'b0;
        step(3);
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", pc); end
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", bus.imem_addr); end
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %b want 0", bus.dec_valid); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_checks++;
        if ({bus.op_code, bus.source1_choice, bus.source2_choice, bus.rd, bus.field_a, bus.field_b} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_fields: got %h %h %h %h %h %h want all 0", bus.op_code, bus.source1_choice,
                     bus.source2_choice, bus.rd, bus.field_a, bus.field_b);
        end
        run = 1'b0;
        rst = 1'b0;
        step(2);
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: got %b want 0", bus.imem_req); end
    endtask

    task automatic test_first_issue();
        fill_mem(32'h01000000);
        mem[0] = 32'h071A0305;
        do_reset();
        bus.dec_ready = 1'b1; run = 1'b1;
        step(1);
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
        n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL first_addr: got %h want 00", bus.imem_addr); end
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL first_c1_valid: got %b want 0", bus.dec_valid); end
        step(1);
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL first_c2_valid: got %b want 0", bus.dec_valid); end
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL first_c2_req: got %b want 0", bus.imem_req); end
        step(1);
        n_checks++; if (bus.dec_valid !== 1'b1) begin n_fail++; $display("FAIL first_c3_valid: got %b want 1", bus.dec_valid); end
        n_checks++; if (bus.op_code !== 8'h07) begin n_fail++; $display("FAIL first_op: got %h want 07", bus.op_code); end
        n_checks++; if (bus.source1_choice !== 2'd0) begin n_fail++; $display("FAIL first_src1: got %0d want 0", bus.source1_choice); end
        n_checks++; if (bus.source2_choice !== 2'd1) begin n_fail++; $display("FAIL first_src2: got %0d want 1", bus.source2_choice); end
        n_checks++; if (bus.rd !== 4'hA) begin n_fail++; $display("FAIL first_rd: got %h want a", bus.rd); end
        n_checks++; if (bus.field_a !== 8'h03) begin n_fail++; $display("FAIL first_field_a: got %h want 03", bus.field_a); end
        n_checks++; if (bus.field_b !== 8'h05) begin n_fail++; $display("FAIL first_field_b: got %h want 05", bus.field_b); end
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL first_pc_before: got %h want 00", pc); end
        step(1);
        n_checks++; if (pc !== 8'h01) begin n_fail++; $display("FAIL first_pc_after: got %h want 01", pc); end
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid_drop: got %b want 0", bus.dec_valid); end
        n_checks++; if (bus.imem_addr !== 8'h01) begin n_fail++; $display("FAIL first_next_addr: got %h want 01", bus.imem_addr); end
    endtask

    task automatic test_hold();
        fill_mem(32'h01000000);
        mem[0] = 32'h0A5BC37E;
        do_reset();
        bus.dec_ready = 1'b0; run = 1'b1;
        step(3);
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (bus.dec_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, bus.dec_valid); end
            n_checks++;
            if ({bus.op_code, bus.source1_choice, bus.source2_choice, bus.rd, bus.field_a, bus.field_b} !== 32'h0A5BC37E) begin
                n_fail++;
                $display("FAIL hold_fields[%0d]: got %h %h %h %h %h %h want 0a 1 1 b c3 7e", i, bus.op_code,
                         bus.source1_choice, bus.source2_choice, bus.rd, bus.field_a, bus.field_b);
            end
            n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL hold_pc[%0d]: got %h want 00", i, pc); end
            n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d]: got %b want 0", i, bus.imem_req); end
            if (i < 5) step(1);
        end
        bus.dec_ready = 1'b1;
        step(1);
        n_checks++; if (pc !== 8'h01) begin n_fail++; $display("FAIL hold_release_pc: got %h want 01", pc); end
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid: got %b want 0", bus.dec_valid); end
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL hold_release_req: got %b want 1", bus.imem_req); end
        step(2);
        n_checks++; if (pc !== 8'h01) begin n_fail++; $display("FAIL hold_single_inc: got %h want 01", pc); end
    endtask

`ifdef INSTR_FETCH_BRANCH_EN
    task automatic test_branch();
        fill_mem(32'h01000000);
        mem[8'h00] = 32'h13000020;
        mem[8'h20] = 32'h13000040;
        mem[8'h21] = 32'h14000050;
        mem[8'h50] = 32'h12000077;
        do_reset();
        cond_in = 1'b1; bus.dec_ready = 1'b1; run = 1'b1;
        step(3);
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL jmpc_taken_valid: got %b want 0", bus.dec_valid); end
        step(1);
        n_checks++; if (bus.imem_addr !== 8'h20) begin n_fail++; $display("FAIL jmpc_taken_addr: got %h want 20", bus.imem_addr); end
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL jmpc_taken_req: got %b want 1", bus.imem_req); end
        cond_in = 1'b0;
        step(2);
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL jmpc_not_valid: got %b want 0", bus.dec_valid); end
        step(1);
        n_checks++; if (bus.imem_addr !== 8'h21) begin n_fail++; $display("FAIL jmpc_not_addr: got %h want 21", bus.imem_addr); end
        step(3);
        n_checks++; if (bus.imem_addr !== 8'h50) begin n_fail++; $display("FAIL jmpcn_addr: got %h want 50", bus.imem_addr); end
        step(2);
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_valid: got %b want 0", bus.dec_valid); end
        step(1);
        n_checks++; if (bus.imem_addr !== 8'h77) begin n_fail++; $display("FAIL jmp_addr: got %h want 77", bus.imem_addr); end
    endtask
`else
    task automatic test_no_branch();
        fill_mem(32'h01000000);
        mem[0] = 32'h12000077;
        mem[1] = 32'h13000020;
        do_reset();
        cond_in = 1'b1; bus.dec_ready = 1'b1; run = 1'b1;
        step(3);
        n_checks++; if (bus.dec_valid !== 1'b1) begin n_fail++; $display("FAIL nobr_jmp_valid: got %b want 1", bus.dec_valid); end
        n_checks++; if (bus.op_code !== 8'h12) begin n_fail++; $display("FAIL nobr_jmp_op: got %h want 12", bus.op_code); end
        step(1);
        n_checks++; if (bus.imem_addr !== 8'h01) begin n_fail++; $display("FAIL nobr_jmp_addr: got %h want 01", bus.imem_addr); end
        step(2);
        n_checks++; if (bus.dec_valid !== 1'b1) begin n_fail++; $display("FAIL nobr_jmpc_valid: got %b want 1", bus.dec_valid); end
        n_checks++; if (bus.op_code !== 8'h13) begin n_fail++; $display("FAIL nobr_jmpc_op: got %h want 13", bus.op_code); end
        step(1);
        n_checks++; if (bus.imem_addr !== 8'h02) begin n_fail++; $display("FAIL nobr_jmpc_addr: got %h want 02", bus.imem_addr); end
    endtask
`endif

    task automatic test_wrap();
        logic found;
        found = 1'b0;
        fill_mem(32'h01000000);
        do_reset();
        bus.dec_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(1);
            if (bus.dec_valid === 1'b1 && pc === 8'hFF) found = 1'b1;
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL wrap_reach_ff: got %b want 1 within 1000 cycles", found); end
        step(1);
        n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_addr: got %h want 00", bus.imem_addr); end
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_req: got %b want 1", bus.imem_req); end
    endtask

    task automatic test_run_stop();
        fill_mem(32'h01000000);
        mem[0] = 32'h05123456;
        do_reset();
        bus.dec_ready = 1'b0; run = 1'b1;
        step(2);
        run = 1'b0;
        step(1);
        n_checks++; if (bus.dec_valid !== 1'b1) begin n_fail++; $display("FAIL stop_issue_valid: got %b want 1", bus.dec_valid); end
        n_checks++; if (bus.op_code !== 8'h05) begin n_fail++; $display("FAIL stop_issue_op: got %h want 05", bus.op_code); end
        step(2);
        n_checks++; if (bus.dec_valid !== 1'b1) begin n_fail++; $display("FAIL stop_still_valid: got %b want 1", bus.dec_valid); end
        bus.dec_ready = 1'b1;
        step(1);
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL stop_valid_drop: got %b want 0", bus.dec_valid); end
        n_checks++; if (pc !== 8'h01) begin n_fail++; $display("FAIL stop_pc: got %h want 01", pc); end
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stop_req: got %b want 0", bus.imem_req); end
        step(2);
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stop_idle_req: got %b want 0", bus.imem_req); end
        run = 1'b1;
        step(1);
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL resume_req: got %b want 1", bus.imem_req); end
        n_checks++; if (bus.imem_addr !== 8'h01) begin n_fail++; $display("FAIL resume_addr: got %h want 01", bus.imem_addr); end
    endtask

    task automatic test_rst_wait();
        fill_mem(32'h01000000);
        mem[1] = 32'h0A5BC37E;
        do_reset();
        bus.dec_ready = 1'b1; run = 1'b1;
        step(5);
        rst = 1'b1; run = 1'b0;
        step(1);
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL rstwait_pc: got %h want 00", pc); end
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_valid: got %b want 0", bus.dec_valid); end
        n_checks++; if (bus.op_code !== 8'h00) begin n_fail++; $display("FAIL rstwait_op: got %h want 00", bus.op_code); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_idle_valid[%0d]: got %b want 0", i, bus.dec_valid); end
            n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rstwait_idle_req[%0d]: got %b want 0", i, bus.imem_req); end
            n_checks++; if (bus.field_a !== 8'h00) begin n_fail++; $display("FAIL rstwait_idle_fa[%0d]: got %h want 00", i, bus.field_a); end
        end
        run = 1'b1;
        step(1);
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rstwait_restart_req: got %b want 1", bus.imem_req); end
        n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL rstwait_restart_addr: got %h want 00", bus.imem_addr); end
    endtask

    task automatic test_halt();
        fill_mem(32'h01000000);
        mem[1] = 32'hFF000000;
        do_reset();
        bus.dec_ready = 1'b1; run = 1'b1;
        step(6);
        n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL halt_issue_valid: got %b want 0", bus.dec_valid); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_not_yet: got %b want 0", halted); end
        for (int i = 0; i < 6; i++) begin
            step(1);
            n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag[%0d]: got %b want 1", i, halted); end
            n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req[%0d]: got %b want 0", i, bus.imem_req); end
            n_checks++; if (bus.dec_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid[%0d]: got %b want 0", i, bus.dec_valid); end
        end
        rst = 1'b1;
        step(1);
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %b want 0", halted); end
        rst = 1'b0; run = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; cond_in = 1'b0; bus.dec_ready = 1'b0;
        test_reset();
        test_first_issue();
        test_hold();
`ifdef INSTR_FETCH_BRANCH_EN
        test_branch();
`else
        test_no_branch();
`endif
        test_wrap();
        test_run_stop();
        test_rst_wait();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
